// File: rtl/icache_ctrl_if.sv
// Bundle for the I-cache controller's three sides: IF-stage fetch, cache RAM, and burst-read bus.
// The master modport is the controller; the slave modport is the environment around it.
interface icache_ctrl_if #(
   parameter int unsigned INDEX_SIZE    = 7,
   parameter int unsigned WORD_OFF_SIZE = 3,
   parameter int unsigned TAG_SIZE      = 20
);
   localparam int unsigned LINE_W = 32 << WORD_OFF_SIZE;

   logic                  cpu_req;
   logic [31:0]           cpu_addr;
   logic                  cpu_addr_ok;
   logic                  cpu_data_ok;
   logic [31:0]           cpu_rdata;

   logic                  ram_wen;
   logic [INDEX_SIZE-1:0] ram_a;
   logic [INDEX_SIZE-1:0] ram_dpra;
   logic [TAG_SIZE-1:0]   ram_d;
   logic [TAG_SIZE-1:0]   ram_dpo;
   logic [LINE_W-1:0]     ram_dina;
   logic [LINE_W-1:0]     ram_douta;
   logic                  ram_w_valid;
   logic                  ram_cache_valid;

   logic                  mem_req;
   logic [31:0]           mem_addr;
   logic                  mem_addr_ok;
   logic                  mem_rvalid;
   logic [31:0]           mem_rdata;

   modport master (
      input  cpu_req, cpu_addr,
      output cpu_addr_ok, cpu_data_ok, cpu_rdata,
      output ram_wen, ram_a, ram_dpra, ram_d, ram_dina, ram_w_valid,
      input  ram_dpo, ram_douta, ram_cache_valid,
      output mem_req, mem_addr,
      input  mem_addr_ok, mem_rvalid, mem_rdata
   );

   modport slave (
      output cpu_req, cpu_addr,
      input  cpu_addr_ok, cpu_data_ok, cpu_rdata,
      input  ram_wen, ram_a, ram_dpra, ram_d, ram_dina, ram_w_valid,
      output ram_dpo, ram_douta, ram_cache_valid,
      input  mem_req, mem_addr,
      output mem_addr_ok, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache sequencer: tag lookup, line refill by burst read, RAM write, replay.
// Interface parameters must match the module parameters.
module icache_ctrl #(
   parameter int unsigned INDEX_SIZE    = 7,
   parameter int unsigned WORD_OFF_SIZE = 3,
   parameter int unsigned TAG_SIZE      = 20
) (
   input  logic          clk,
   input  logic          resetn,
   icache_ctrl_if.master bus
);
   localparam int unsigned LINE_WORDS = 1 << WORD_OFF_SIZE;
   localparam int unsigned WORD_LSB   = 2;
   localparam int unsigned INDEX_LSB  = WORD_LSB + WORD_OFF_SIZE;
   localparam int unsigned TAG_LSB    = INDEX_LSB + INDEX_SIZE;
   localparam int unsigned LINE_OFF_W = WORD_OFF_SIZE + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MISS,
      S_REFILL,
      S_WRITE
   } state_t;

   state_t                              state_q, state_d;
   logic [TAG_SIZE-1:0]                 tag_q;
   logic [INDEX_SIZE-1:0]               idx_q;
   logic [WORD_OFF_SIZE-1:0]            word_q;
   logic [WORD_OFF_SIZE-1:0]            cnt_q;
   logic [LINE_WORDS-1:0][31:0]         line_q;
   logic [LINE_WORDS-1:0][31:0]         rd_line;
   logic                                hit;
   logic                                accept;
   logic                                beat;
   logic                                clr_cnt;

   assign rd_line = bus.ram_douta;
   assign hit     = bus.ram_cache_valid && (bus.ram_dpo == tag_q);

   // Next state and all controller outputs; everything is forced quiet while resetn is low.
   always_comb begin
      state_d          = state_q;
      accept           = 1'b0;
      beat             = 1'b0;
      clr_cnt          = 1'b0;
      bus.cpu_addr_ok  = 1'b0;
      bus.cpu_data_ok  = 1'b0;
      bus.cpu_rdata    = '0;
      bus.ram_wen      = 1'b0;
      bus.ram_w_valid  = 1'b0;
      bus.ram_a        = idx_q;
      bus.ram_dpra     = idx_q;
      bus.ram_d        = tag_q;
      bus.ram_dina     = line_q;
      bus.mem_req      = 1'b0;
      bus.mem_addr     = {tag_q, idx_q, LINE_OFF_W'(0)};

      unique case (state_q)
         S_IDLE: begin
            bus.cpu_addr_ok = 1'b1;
            if (bus.cpu_req) begin
               accept  = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               bus.cpu_data_ok = 1'b1;
               bus.cpu_rdata   = rd_line[word_q];
               bus.cpu_addr_ok = 1'b1;
               if (bus.cpu_req) accept  = 1'b1;
               else             state_d = S_IDLE;
            end else begin
               state_d = S_MISS;
            end
         end
         S_MISS: begin
            bus.mem_req = 1'b1;
            if (bus.mem_addr_ok) begin
               clr_cnt = 1'b1;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (bus.mem_rvalid) begin
               beat = 1'b1;
               if (cnt_q == WORD_OFF_SIZE'(LINE_WORDS - 1)) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            bus.ram_wen     = 1'b1;
            bus.ram_w_valid = 1'b1;
            state_d         = S_LOOKUP;
         end
         default: state_d = S_IDLE;
      endcase

      // A reset edge must not see a handshake or a RAM write from the state being abandoned.
      if (!resetn) begin
         bus.cpu_addr_ok = 1'b0;
         bus.cpu_data_ok = 1'b0;
         bus.cpu_rdata   = '0;
         bus.ram_wen     = 1'b0;
         bus.ram_w_valid = 1'b0;
         bus.mem_req     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         tag_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            tag_q  <= bus.cpu_addr[TAG_LSB +: TAG_SIZE];
            idx_q  <= bus.cpu_addr[INDEX_LSB +: INDEX_SIZE];
            word_q <= bus.cpu_addr[WORD_LSB +: WORD_OFF_SIZE];
         end
         if (clr_cnt) begin
            cnt_q <= '0;
         end else if (beat) begin
            line_q[cnt_q] <= bus.mem_rdata;
            cnt_q         <= cnt_q + WORD_OFF_SIZE'(1);
         end
      end
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: behavioural cache RAM, hand-driven burst bus, vector table for hit streams.
module tb_icache_ctrl;
   localparam int unsigned IDX = 7;
   localparam int unsigned WO  = 3;
   localparam int unsigned TW  = 20;
   localparam int unsigned LW  = 32 << WO;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   icache_ctrl_if #(.INDEX_SIZE(IDX), .WORD_OFF_SIZE(WO), .TAG_SIZE(TW)) bus ();

   icache_ctrl #(.INDEX_SIZE(IDX), .WORD_OFF_SIZE(WO), .TAG_SIZE(TW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Cache RAM model: combinational read, synchronous write, valid bits cleared by reset.
   logic [TW-1:0]    tag_mem  [128];
   logic [LW-1:0]    data_mem [128];
   logic [127:0]     vld;

   assign bus.ram_dpo         = tag_mem[bus.ram_dpra];
   assign bus.ram_douta       = data_mem[bus.ram_dpra];
   assign bus.ram_cache_valid = vld[bus.ram_dpra];

   always @(posedge clk) begin
      if (!resetn) begin
         vld <= '0;
      end else if (bus.ram_wen) begin
         tag_mem[bus.ram_a]  <= bus.ram_d;
         data_mem[bus.ram_a] <= bus.ram_dina;
         vld[bus.ram_a]      <= bus.ram_w_valid;
      end
   end

   int checks    = 0;
   int errors    = 0;
   int wen_cnt   = 0;
   int memreq_cnt = 0;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        exp_dok;
      logic [31:0] exp_rdata;
      logic        exp_aok;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, then sample outputs 1ns later.
   task automatic cycle(input logic req, input logic [31:0] addr, input logic aok,
                        input logic rv, input logic [31:0] rd);
      @(negedge clk);
      bus.cpu_req     = req;
      bus.cpu_addr    = addr;
      bus.mem_addr_ok = aok;
      bus.mem_rvalid  = rv;
      bus.mem_rdata   = rd;
      #1;
      if (bus.ram_wen) wen_cnt++;
      if (bus.mem_req) memreq_cnt++;
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // Issue a fetch expected to miss; wait for the burst request, return at most 4 cycles later.
   task automatic miss_start(input logic [31:0] addr, output logic found);
      cycle(1'b1, addr, 1'b0, 1'b0, 32'h0);
      chk($sformatf("accept_aok@%h", addr), bus.cpu_addr_ok, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         idle();
         if (bus.mem_req) found = 1'b1;
         else chk($sformatf("lookup_no_data@%h", addr), bus.cpu_data_ok, 1'b0);
      end
      chk($sformatf("mem_req_seen@%h", addr), found, 1'b1);
      chk($sformatf("mem_addr@%h", addr), bus.mem_addr, addr & 32'hFFFF_FFE0);
      chk($sformatf("miss_aok@%h", addr), bus.cpu_addr_ok, 1'b0);
   endtask

   task automatic refill_seq(input logic [31:0] addr, input logic [31:0] dbase,
                             input int stall, input int gap);
      logic          found;
      logic [255:0]  exp_line;
      int            w0;
      for (int b = 0; b < 8; b++) exp_line[32*b +: 32] = dbase + 32'(b);
      miss_start(addr, found);
      if (!found) return;
      // Address phase stall; stray rvalid here must be ignored
      for (int i = 0; i < stall; i++) begin
         cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i));
         chk($sformatf("stall_req@%h", addr), bus.mem_req, 1'b1);
         chk($sformatf("stall_addr@%h", addr), bus.mem_addr, addr & 32'hFFFF_FFE0);
         chk($sformatf("stall_aok@%h", addr), bus.cpu_addr_ok, 1'b0);
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("handshake_req@%h", addr), bus.mem_req, 1'b1);
      w0 = wen_cnt;
      for (int b = 0; b < 8; b++) begin
         for (int g = 0; g < gap; g++) begin
            cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'hBAD0_0000);
            chk($sformatf("gap_aok@%h", addr), bus.cpu_addr_ok, 1'b0);
         end
         cycle(1'b0, 32'h0, 1'b0, 1'b1, dbase + 32'(b));
         chk($sformatf("beat_aok@%h", addr), bus.cpu_addr_ok, 1'b0);
      end
      chk($sformatf("no_early_wen@%h", addr), 32'(wen_cnt - w0), 32'd0);
      idle();
      chk($sformatf("wen@%h", addr), bus.ram_wen, 1'b1);
      chk($sformatf("wen_idx@%h", addr), bus.ram_a, addr[11:5]);
      chk($sformatf("wen_tag@%h", addr), bus.ram_d, addr[31:12]);
      chk($sformatf("wen_line@%h", addr), bus.ram_dina, exp_line);
      chk($sformatf("wen_valid@%h", addr), bus.ram_w_valid, 1'b1);
      chk($sformatf("write_no_data@%h", addr), bus.cpu_data_ok, 1'b0);
      idle();
      chk($sformatf("replay_dok@%h", addr), bus.cpu_data_ok, 1'b1);
      chk($sformatf("replay_rdata@%h", addr), bus.cpu_rdata, dbase + 32'(addr[4:2]));
      idle();
      chk($sformatf("single_dok@%h", addr), bus.cpu_data_ok, 1'b0);
      chk($sformatf("back_idle@%h", addr), bus.cpu_addr_ok, 1'b1);
      chk($sformatf("one_wen@%h", addr), 32'(wen_cnt - w0), 32'd1);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      int m0;
      m0 = memreq_cnt;
      for (int i = lo; i <= hi; i++) begin
         cycle(vecs[i].req, vecs[i].addr, 1'b0, 1'b0, 32'h0);
         chk($sformatf("vec%0d_dok", i), bus.cpu_data_ok, vecs[i].exp_dok);
         if (vecs[i].exp_dok) chk($sformatf("vec%0d_rdata", i), bus.cpu_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_aok", i), bus.cpu_addr_ok, vecs[i].exp_aok);
      end
      chk($sformatf("vecs%0d_no_memreq", lo), 32'(memreq_cnt - m0), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic found;
      int   w0;

      vecs[0] = '{1'b1, 32'h1FC0_0000, 1'b0, 32'h0,  1'b1};
      vecs[1] = '{1'b1, 32'h1FC0_0008, 1'b1, 32'hA0, 1'b1};
      vecs[2] = '{1'b1, 32'h1FC0_001C, 1'b1, 32'hA2, 1'b1};
      vecs[3] = '{1'b0, 32'h0,         1'b1, 32'hA7, 1'b1};
      vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0,  1'b1};
      vecs[5] = '{1'b1, 32'h0000_0FE4, 1'b0, 32'h0,  1'b1};
      vecs[6] = '{1'b1, 32'h0000_1004, 1'b1, 32'hD1, 1'b1};
      vecs[7] = '{1'b0, 32'h0,         1'b1, 32'hE1, 1'b1};
      vecs[8] = '{1'b0, 32'h0,         0,    32'h0,  1'b1};

      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.mem_addr_ok = 1'b0;
      bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

      // Reset state
      resetn = 1'b0;
      repeat (3) idle();
      chk("rst_aok", bus.cpu_addr_ok, 1'b0);
      chk("rst_dok", bus.cpu_data_ok, 1'b0);
      chk("rst_rdata", bus.cpu_rdata, 32'h0);
      chk("rst_memreq", bus.mem_req, 1'b0);
      chk("rst_wen", bus.ram_wen, 1'b0);
      @(negedge clk); resetn = 1'b1;
      idle();
      chk("post_rst_aok", bus.cpu_addr_ok, 1'b1);

      // Cold miss, then back-to-back hits
      refill_seq(32'h1FC0_0004, 32'hA0, 0, 0);
      run_vecs(0, 4);

      // Conflict miss overwrites line 0; original tag misses again over a stalled bus
      refill_seq(32'h2FC0_0000, 32'hB0, 0, 0);
      refill_seq(32'h1FC0_0000, 32'hA0, 10, 2);

      // Reset after four beats of a refill
      miss_start(32'h2FC0_0004, found);
      if (found) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
         for (int b = 0; b < 4; b++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hF0 + 32'(b));
      end
      w0 = wen_cnt;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         resetn = 1'b0;
         bus.cpu_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_rvalid = 1'b0;
         #1;
         if (bus.ram_wen) wen_cnt++;
         chk("midrst_aok", bus.cpu_addr_ok, 1'b0);
         chk("midrst_memreq", bus.mem_req, 1'b0);
      end
      @(negedge clk); resetn = 1'b1;
      repeat (3) idle();
      chk("midrst_idle", bus.cpu_addr_ok, 1'b1);
      chk("midrst_no_wen", 32'(wen_cnt - w0), 32'd0);
      refill_seq(32'h1FC0_0000, 32'hC0, 0, 1);

      // Index wrap: lines 127 and 0 are independent
      refill_seq(32'h0000_0FE0, 32'hD0, 0, 0);
      refill_seq(32'h0000_1000, 32'hE0, 1, 0);
      run_vecs(5, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
